// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the PC and the IF/ID register.
// Issues a read at the current PC, tells the PC when to advance, captures the
// returned word into IF/ID, and parks one word in a skid buffer when decode
// stalls so a memory hit is never lost. Redirects flush everything fetched;
// a halt opcode parks the front end until the next flush or reset.
module fetch_unit #(
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_val,
  output logic        pc_ihit,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        flush,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT_ID = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        accept;

  // Decode can take a new entry when IF/ID is empty or being consumed.
  assign accept = !ifid_valid || !stall;

  // Memory-side and PC-side controls. A flush always advances the PC so the
  // redirect target loads, and suppresses the read for that cycle.
  always_comb begin
    imemREN  = (state == FETCH) && !flush;
    imemaddr = pc_val;
    pc_ihit  = ((state == FETCH) && ihit && !flush) || flush;
    halted   = (state == HALTED);
  end

  // Fetch FSM with IF/ID register and one-entry skid buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= FETCH;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_npc   <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      // Skid contents are dead once state leaves WAIT_ID; no separate valid.
      state      <= FETCH;
      ifid_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (ihit) begin
            if (accept) begin
              ifid_valid <= 1'b1;
              ifid_instr <= imemload;
              ifid_pc    <= pc_val;
              ifid_npc   <= pc_val + PC_STEP;
              state      <= (imemload[31:26] == HALT_OP) ? HALTED : FETCH;
            end else begin
              // PC already advanced on this hit, so the word must be parked.
              skid_instr <= imemload;
              skid_pc    <= pc_val;
              state      <= WAIT_ID;
            end
          end else if (ifid_valid && !stall) begin
            ifid_valid <= 1'b0;
          end
        end
        WAIT_ID: begin
          if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_instr <= skid_instr;
            ifid_pc    <= skid_pc;
            ifid_npc   <= skid_pc + PC_STEP;
            state      <= (skid_instr[31:26] == HALT_OP) ? HALTED : FETCH;
          end
        end
        HALTED: begin
          if (!stall) ifid_valid <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall skid, flush priority,
// halt parking, PC wrap and asynchronous reset during WAIT_ID.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_val;
  logic        pc_ihit;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_npc;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .pc_val(pc_val), .pc_ihit(pc_ihit),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .stall(stall), .flush(flush), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_npc(ifid_npc),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one cycle of fetch-side inputs and let combinational paths settle.
  task automatic drive(input logic h, input logic [31:0] pc, input logic [31:0] w,
                       input logic st, input logic fl);
    ihit = h; pc_val = pc; imemload = w; stall = st; flush = fl;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    // Reset state
    chk("rst_imemREN", {31'b0, imemREN}, 32'd1);
    chk("rst_pc_ihit", {31'b0, pc_ihit}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Streaming
    drive(1'b1, 32'h0, 32'h20010001, 1'b0, 1'b0);
    chk("str0_pc_ihit", {31'b0, pc_ihit}, 32'd1);
    chk("str0_imemaddr", imemaddr, 32'h0);
    tick();
    chk("str0_valid", {31'b0, ifid_valid}, 32'd1);
    chk("str0_instr", ifid_instr, 32'h20010001);
    chk("str0_npc", ifid_npc, 32'h4);
    drive(1'b1, 32'h4, 32'h20020002, 1'b0, 1'b0);
    chk("str1_pc_ihit", {31'b0, pc_ihit}, 32'd1);
    tick();
    chk("str1_instr", ifid_instr, 32'h20020002);
    chk("str1_npc", ifid_npc, 32'h8);
    drive(1'b1, 32'h8, 32'h00221820, 1'b0, 1'b0);
    chk("str2_pc_ihit", {31'b0, pc_ihit}, 32'd1);
    tick();
    chk("str2_instr", ifid_instr, 32'h00221820);
    chk("str2_pc", ifid_pc, 32'h8);
    chk("str2_npc", ifid_npc, 32'hC);

    // Stall skid
    drive(1'b1, 32'h0, 32'h20010001, 1'b0, 1'b0);
    tick();
    chk("sk_pre_instr", ifid_instr, 32'h20010001);
    drive(1'b1, 32'h4, 32'h20020002, 1'b1, 1'b0);
    chk("sk_hit_pc_ihit", {31'b0, pc_ihit}, 32'd1);
    tick();
    drive(1'b0, 32'h8, 32'h0, 1'b1, 1'b0);
    chk("sk_w0_imemREN", {31'b0, imemREN}, 32'd0);
    chk("sk_w0_pc_ihit", {31'b0, pc_ihit}, 32'd0);
    chk("sk_w0_instr", ifid_instr, 32'h20010001);
    chk("sk_w0_pc", ifid_pc, 32'h0);
    drive(1'b1, 32'h8, 32'h12345678, 1'b1, 1'b0);
    chk("sk_w0_ihit_ignored", {31'b0, pc_ihit}, 32'd0);
    tick();
    drive(1'b0, 32'h8, 32'h0, 1'b1, 1'b0);
    chk("sk_w1_imemREN", {31'b0, imemREN}, 32'd0);
    chk("sk_w1_instr", ifid_instr, 32'h20010001);
    drive(1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
    tick();
    chk("sk_out_valid", {31'b0, ifid_valid}, 32'd1);
    chk("sk_out_instr", ifid_instr, 32'h20020002);
    chk("sk_out_pc", ifid_pc, 32'h4);
    chk("sk_out_npc", ifid_npc, 32'h8);
    chk("sk_out_imemREN", {31'b0, imemREN}, 32'd1);

    // Flush in FETCH
    drive(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("flF_pc_ihit", {31'b0, pc_ihit}, 32'd1);
    chk("flF_imemREN", {31'b0, imemREN}, 32'd0);
    tick();
    drive(1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
    chk("flF_valid", {31'b0, ifid_valid}, 32'd0);
    chk("flF_imemREN_next", {31'b0, imemREN}, 32'd1);
    n_cmp++;
    assert (ifid_instr !== 32'hDEADBEEF) else begin
      n_err++;
      $error("FAIL flF_nocapture: observed %h expected not deadbeef", ifid_instr);
    end

    // Flush in WAIT_ID
    drive(1'b1, 32'h10, 32'h20030003, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h14, 32'h20040004, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h18, 32'hDEADBEEF, 1'b1, 1'b1);
    chk("flW_pc_ihit", {31'b0, pc_ihit}, 32'd1);
    tick();
    drive(1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
    chk("flW_valid", {31'b0, ifid_valid}, 32'd0);
    chk("flW_imemREN", {31'b0, imemREN}, 32'd1);
    tick();
    chk("flW_skid_dropped", {31'b0, ifid_valid}, 32'd0);

    // Halt
    drive(1'b1, 32'h20, 32'hFC000000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h24, 32'h20070007, 1'b0, 1'b0);
    chk("h_valid", {31'b0, ifid_valid}, 32'd1);
    chk("h_instr", ifid_instr, 32'hFC000000);
    chk("h_halted", {31'b0, halted}, 32'd1);
    chk("h_imemREN", {31'b0, imemREN}, 32'd0);
    chk("h_pc_ihit", {31'b0, pc_ihit}, 32'd0);
    tick();
    chk("h_drain_valid", {31'b0, ifid_valid}, 32'd0);
    chk("h_still_halted", {31'b0, halted}, 32'd1);
    chk("h_pc_ihit2", {31'b0, pc_ihit}, 32'd0);
    drive(1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
    chk("h_flush_pc_ihit", {31'b0, pc_ihit}, 32'd1);
    tick();
    drive(1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
    chk("h_exit_halted", {31'b0, halted}, 32'd0);
    chk("h_exit_imemREN", {31'b0, imemREN}, 32'd1);

    // PC wrap
    drive(1'b1, 32'hFFFFFFFC, 32'h20050005, 1'b0, 1'b0);
    tick();
    chk("wrap_pc", ifid_pc, 32'hFFFFFFFC);
    chk("wrap_npc", ifid_npc, 32'h00000000);

    // Async reset during WAIT_ID
    drive(1'b1, 32'h40, 32'h20060006, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h44, 32'h0, 1'b1, 1'b0);
    chk("r_wait_imemREN", {31'b0, imemREN}, 32'd0);
    #2;
    RST = 1'b1;
    #1;
    chk("r_valid", {31'b0, ifid_valid}, 32'd0);
    chk("r_instr", ifid_instr, 32'h0);
    chk("r_pc", ifid_pc, 32'h0);
    chk("r_npc", ifid_npc, 32'h0);
    chk("r_imemREN", {31'b0, imemREN}, 32'd1);
    chk("r_halted", {31'b0, halted}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
    tick();
    chk("r_post_valid", {31'b0, ifid_valid}, 32'd0);
    chk("r_post_imemREN", {31'b0, imemREN}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
